// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: state encodings and default width shared with the ripple adder
package serial_subtractor_pkg;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;
  localparam int DEF_WIDTH = 8;
endpackage

// File: rtl/adder_1bit.sv
// adder_1bit: full-adder cell shared by the ripple adder and the serial subtractor
module adder_1bit (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);
  assign S = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A - B, LSB first, as A + ~B + 1 through one adder cell
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             V,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] sa, sb;
  logic [CW-1:0] cnt;
  logic carry, a_msb, b_msb, s, c_o;
  adder_1bit u_add (.A(sa[0]), .B(sb[0]), .Cin(carry), .S(s), .Cout(c_o));
  assign ready = state == S_IDLE;
  assign busy = state == S_RUN;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      sa <= '0;
      sb <= '0;
      cnt <= '0;
      carry <= 1'b0;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      D <= '0;
      Bout <= 1'b0;
      V <= 1'b0;
      done <= 1'b0;
    end else
      case (state)
        S_IDLE:
          if (start) begin
            state <= S_RUN;
            sa <= A;
            sb <= ~B;
            carry <= 1'b1;
            cnt <= '0;
            a_msb <= A[WIDTH-1];
            b_msb <= B[WIDTH-1];
            D <= '0;
            Bout <= 1'b0;
            V <= 1'b0;
          end
        S_RUN: begin
          D <= {s, D[WIDTH-1:1]};
          sa <= sa >> 1;
          sb <= sb >> 1;
          carry <= c_o;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            Bout <= ~c_o;
            V <= (a_msb != b_msb) && (s != a_msb);
            done <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          done <= 1'b0;
          state <= S_IDLE;
        end
      endcase
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: scoreboard bench for 8-bit random/directed ops and exhaustive 4-bit back-to-back ops
module tb_serial_subtractor;
  typedef struct {logic [7:0] d; logic bo; logic v; int acc;} exp_t;
  logic clk = 0, rst = 1;
  logic start8 = 0, start4 = 0;
  logic [7:0] A8 = 0, B8 = 0, D8;
  logic [3:0] A4 = 0, B4 = 0, D4;
  logic ready8, busy8, Bout8, V8, done8;
  logic ready4, busy4, Bout4, V4, done4;
  int cyc = 0, n_chk = 0, n_fail = 0, dc8 = 0, dc4 = 0;
  exp_t q8[$], q4[$];
  serial_subtractor #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8),
    .ready(ready8), .busy(busy8), .D(D8), .Bout(Bout8), .V(V8), .done(done8));
  serial_subtractor #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4),
    .ready(ready4), .busy(busy4), .D(D4), .Bout(Bout4), .V(V4), .done(done4));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic exp_t model(input int a, input int b, input int w, input int acc);
    exp_t m;
    int sa, sb, diff;
    sa = a >= (1 << (w - 1)) ? a - (1 << w) : a;
    sb = b >= (1 << (w - 1)) ? b - (1 << w) : b;
    diff = sa - sb;
    m.d = 8'((a - b) & ((1 << w) - 1));
    m.bo = a < b;
    m.v = diff > (1 << (w - 1)) - 1 || diff < -(1 << (w - 1));
    m.acc = acc;
    return m;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done8) begin
      dc8++;
      chk("q8 nonempty at done", q8.size() > 0, 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("D8", D8, e.d);
        chk("Bout8", Bout8, e.bo);
        chk("V8", V8, e.v);
        chk("latency8", cyc - e.acc, 8);
      end
    end
  end
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done4) begin
      dc4++;
      chk("q4 nonempty at done", q4.size() > 0, 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("D4", D4, e.d);
        chk("Bout4", Bout4, e.bo);
        chk("V4", V4, e.v);
        chk("latency4", cyc - e.acc, 4);
      end
    end
  end
  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    while (!ready8 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("ready8 wait", ready8, 1);
    A8 = a;
    B8 = b;
    start8 = 1;
    q8.push_back(model(a, b, 8, cyc + 1));
    @(negedge clk);
    start8 = 0;
  endtask
  task automatic drain8();
    int k = 0;
    while ((q8.size() != 0 || !ready8) && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("drain8", q8.size(), 0);
  endtask
  initial begin
    int d0, prev, k;
    repeat (2) @(negedge clk);
    chk("rst D", D8, 0);
    chk("rst Bout", Bout8, 0);
    chk("rst V", V8, 0);
    chk("rst done", done8, 0);
    chk("rst ready", ready8, 1);
    chk("rst busy", busy8, 0);
    rst = 0;
    @(negedge clk);
    op8(100, 37);
    chk("busy after accept", busy8, 1);
    chk("ready after accept", ready8, 0);
    drain8();
    chk("t1 D", D8, 63);
    op8(5, 9);
    op8(8'hFF, 8'hFF);
    op8(8'h80, 8'h01);
    op8(8'h7F, 8'hFF);
    drain8();
    chk("t3 D", D8, 8'h80);
    chk("t3 V", V8, 1);
    chk("t3 Bout", Bout8, 1);
    repeat (40) op8(8'($urandom), 8'($urandom));
    drain8();
    d0 = dc8;
    op8(50, 20);
    repeat (3) begin
      start8 = 1;
      A8 = 8'($urandom);
      B8 = 8'($urandom);
      @(negedge clk);
    end
    start8 = 0;
    drain8();
    chk("t4 done count", dc8 - d0, 1);
    chk("t4 D", D8, 30);
    op8(200, 1);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    chk("abort D", D8, 0);
    chk("abort Bout", Bout8, 0);
    chk("abort V", V8, 0);
    chk("abort done", done8, 0);
    chk("abort ready", ready8, 1);
    chk("abort busy", busy8, 0);
    q8.delete();
    d0 = dc8;
    @(negedge clk);
    rst = 0;
    repeat (12) @(negedge clk);
    chk("abort no done", dc8 - d0, 0);
    op8(10, 3);
    drain8();
    chk("t5 D", D8, 7);
    start4 = 1;
    prev = 0;
    for (int i = 0; i < 256; i++) begin
      k = 0;
      while (!ready4 && k < 20) begin
        @(negedge clk);
        k++;
      end
      chk("ready4 wait", ready4, 1);
      if (i > 0) chk("ready spacing", cyc - prev, 6);
      prev = cyc;
      A4 = 4'(i >> 4);
      B4 = 4'(i);
      q4.push_back(model(i >> 4, i & 15, 4, cyc + 1));
      @(negedge clk);
    end
    start4 = 0;
    k = 0;
    while ((q4.size() != 0 || !ready4) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drain4", q4.size(), 0);
    chk("done4 count", dc4, 256);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
